conv_kernel_array_pipe: RTL and testbench

- Parametrised successor to the fixed 6-lane convolution kernel array in the conv layer.
- ARRAY_SIZE lanes of signed fixed-point multiply-accumulate share one broadcast weight stream.
- Each lane accumulates one KERNEL_TAPS-tap window, adds a shared bias, applies optional ReLU, then rounds and saturates.
- Adds a valid/ready handshake, a tap counter, a 2-stage stallable pipeline, per-lane masking and a registered result bus.
- Sits between the conv line cache (pixel bus source) and the pooling/output writer.

---
 rtl/conv_array_pkg.sv | 19 +
 rtl/conv_mac_lane.sv | 91 +++++++++
 rtl/conv_kernel_array_pipe.sv | 112 +++++++++++
 tb/tb_conv_kernel_array_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_array_pkg.sv
// Shared constants for the convolution kernel array.
// Holds the default geometry (lanes, operand width, fraction bits, taps),
// the accumulator width formula and the default saturation limits.
package conv_array_pkg;

  localparam int unsigned DefArraySize  = 6;
  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefFracBits   = 8;
  localparam int unsigned DefKernelTaps = 9;

  // Wide enough for KERNEL_TAPS full-scale products plus the shifted bias.
  function automatic int unsigned acc_width(int unsigned data_width, int unsigned taps);
    return 2 * data_width + $clog2(taps) + 1;
  endfunction

  localparam logic signed [DefDataWidth-1:0] DefSatMax = {1'b0, {(DefDataWidth-1){1'b1}}};
  localparam logic signed [DefDataWidth-1:0] DefSatMin = {1'b1, {(DefDataWidth-1){1'b0}}};

endpackage

// File: rtl/conv_mac_lane.sv
// One multiply-accumulate lane of the kernel array.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   adv                 pipeline advance (low = hold everything)
//   load                accepted beat: capture pixel*weight into the product register
//   valid, first, last  stage-1 flags for the product register contents
//   clear               flush accumulator (the output register is kept)
//   pixel, weight, bias signed fixed-point operands (bias latched by the top)
//   relu, enable        window options latched by the top on the tap-0 beat
//   result              registered, rounded, saturated lane result
module conv_mac_lane
  import conv_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned FRAC_BITS   = DefFracBits,
  parameter int unsigned KERNEL_TAPS = DefKernelTaps
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adv,
  input  logic                         load,
  input  logic                         valid,
  input  logic                         first,
  input  logic                         last,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] pixel,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         relu,
  input  logic                         enable,
  output logic        [DATA_WIDTH-1:0] result
);

  localparam int unsigned AccWidth  = acc_width(DATA_WIDTH, KERNEL_TAPS);
  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

  localparam logic signed [AccWidth-1:0] SatMax =
    {{(AccWidth-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] SatMin =
    {{(AccWidth-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ProdWidth-1:0]  prod_d, prod_q;
  logic signed [AccWidth-1:0]   acc_q, prod_ext, bias_ext, sum, shifted;
  logic        [DATA_WIDTH-1:0] result_d, result_q;

  always_comb begin
    prod_d   = $signed({{DATA_WIDTH{pixel[DATA_WIDTH-1]}}, pixel}) *
               $signed({{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight});
    prod_ext = {{(AccWidth-ProdWidth){prod_q[ProdWidth-1]}}, prod_q};
    // Bias is aligned to the product's 2*FRAC_BITS fraction.
    bias_ext = {{(AccWidth-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;
    sum      = first ? (bias_ext + prod_ext) : (acc_q + prod_ext);
    // Arithmetic shift: rounds toward -inf back to FRAC_BITS fraction.
    shifted  = sum >>> FRAC_BITS;

    result_d = shifted[DATA_WIDTH-1:0];
    if (relu && shifted[AccWidth-1]) begin
      result_d = '0;
    end else if (shifted > SatMax) begin
      result_d = SatMax[DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      result_d = SatMin[DATA_WIDTH-1:0];
    end
    if (!enable) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (adv && load) begin
        prod_q <= prod_d;
      end
      if (clear) begin
        acc_q <= '0;
      end else if (adv && valid) begin
        acc_q <= sum;
      end
      if (adv && valid && last && !clear) begin
        result_q <= result_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: rtl/conv_kernel_array_pipe.sv
// Parametrised convolution kernel array: ARRAY_SIZE signed fixed-point MAC
// lanes share a broadcast weight stream, each summing a KERNEL_TAPS window
// plus a shared bias, with optional ReLU, rounding, saturation and masking.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_pixel_bus         one pixel per lane, lane 0 in the MSBs
//   i_weight            weight broadcast to all lanes
//   i_bias, i_lane_mask, i_relu  window options, sampled on the tap-0 beat
//   i_valid / o_ready   input beat handshake
//   clear               synchronous flush of any partial window
//   o_pixel_bus         registered results, same lane order as the input
//   o_valid / i_ready   output handshake
module conv_kernel_array_pipe
  import conv_array_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE  = DefArraySize,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned FRAC_BITS   = DefFracBits,
  parameter int unsigned KERNEL_TAPS = DefKernelTaps
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus,
  input  logic [DATA_WIDTH-1:0]          i_weight,
  input  logic [DATA_WIDTH-1:0]          i_bias,
  input  logic [ARRAY_SIZE-1:0]          i_lane_mask,
  input  logic                           i_relu,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           clear,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_pixel_bus,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam int unsigned CntWidth = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
  localparam logic [CntWidth-1:0] LastTap = CntWidth'(KERNEL_TAPS - 1);

  logic                  adv, accept, load_out;
  logic [CntWidth-1:0]   tap_cnt_q;
  logic                  s1_valid_q, s1_first_q, s1_last_q;
  logic [DATA_WIDTH-1:0] bias_q;
  logic [ARRAY_SIZE-1:0] mask_q;
  logic                  relu_q, valid_q;

  // The whole pipeline stalls only when a result is waiting and not taken.
  assign adv      = ~(valid_q & ~i_ready);
  assign o_ready  = adv;
  assign accept   = i_valid & adv & ~clear;
  assign load_out = adv & s1_valid_q & s1_last_q & ~clear;
  assign o_valid  = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      bias_q     <= '0;
      mask_q     <= '0;
      relu_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (clear) begin
        tap_cnt_q  <= '0;
        s1_valid_q <= 1'b0;
      end else if (adv) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_first_q <= (tap_cnt_q == '0);
          s1_last_q  <= (tap_cnt_q == LastTap);
          tap_cnt_q  <= (tap_cnt_q == LastTap) ? '0 : tap_cnt_q + 1'b1;
          if (tap_cnt_q == '0) begin
            bias_q <= i_bias;
            mask_q <= i_lane_mask;
            relu_q <= i_relu;
          end
        end
      end
      // A new result loading on the unload edge keeps o_valid high.
      if (load_out) begin
        valid_q <= 1'b1;
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    conv_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .KERNEL_TAPS(KERNEL_TAPS)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .load  (accept),
      .valid (s1_valid_q),
      .first (s1_first_q),
      .last  (s1_last_q),
      .clear (clear),
      .pixel (i_pixel_bus[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH]),
      .weight(i_weight),
      .bias  (bias_q),
      .relu  (relu_q),
      .enable(mask_q[k]),
      .result(o_pixel_bus[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_conv_kernel_array_pipe.sv
// Self-checking bench for conv_kernel_array_pipe: directed scenarios plus
// randomized windows, scored against a plain-arithmetic window model.
module tb_conv_kernel_array_pipe;
  import conv_array_pkg::*;

  localparam int AS = DefArraySize;
  localparam int DW = DefDataWidth;
  localparam int FB = DefFracBits;
  localparam int KT = DefKernelTaps;
  localparam int BW = AS * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] i_pixel_bus;
  logic [DW-1:0] i_weight, i_bias;
  logic [AS-1:0] i_lane_mask;
  logic          i_relu, i_valid, o_ready, clear, o_valid, i_ready;
  logic [BW-1:0] o_pixel_bus;

  int checks = 0;
  int failures = 0;

  // Window model state.
  logic [BW-1:0] exp_q[$];
  longint        m_acc[AS];
  int            m_tap = 0;
  logic [AS-1:0] m_mask;
  bit            m_relu;

  always #5 clk = ~clk;

  conv_kernel_array_pipe #(
    .ARRAY_SIZE (AS),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .KERNEL_TAPS(KT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pixel_bus(i_pixel_bus),
    .i_weight   (i_weight),
    .i_bias     (i_bias),
    .i_lane_mask(i_lane_mask),
    .i_relu     (i_relu),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .clear      (clear),
    .o_pixel_bus(o_pixel_bus),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  task automatic check_bus(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_result();
    logic [BW-1:0] bus;
    longint r;
    for (int k = 0; k < AS; k++) begin
      r = m_acc[k] >>> FB;
      if (m_relu && r < 0) r = 0;
      if (r > longint'(DefSatMax)) r = longint'(DefSatMax);
      if (r < longint'(DefSatMin)) r = longint'(DefSatMin);
      if (!m_mask[k]) r = 0;
      bus[(AS-k)*DW-1 -: DW] = r[DW-1:0];
    end
    return bus;
  endfunction

  task automatic model_beat();
    longint p, w;
    if (m_tap == 0) begin
      m_mask = i_lane_mask;
      m_relu = i_relu;
      for (int k = 0; k < AS; k++) m_acc[k] = longint'($signed(i_bias)) * (longint'(1) << FB);
    end
    w = longint'($signed(i_weight));
    for (int k = 0; k < AS; k++) begin
      p = longint'($signed(i_pixel_bus[(AS-k)*DW-1 -: DW]));
      m_acc[k] += p * w;
    end
    m_tap++;
    if (m_tap == KT) begin
      exp_q.push_back(model_result());
      m_tap = 0;
    end
  endtask

  // One clock: sample at the falling edge, then return 1 ns after the rising edge.
  task automatic tick(output bit got);
    @(negedge clk);
    check_val("o_ready", int'(o_ready), int'(!(o_valid && !i_ready)));
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) check_val("spurious_result", int'(o_valid), 0);
      else check_bus("result", o_pixel_bus, exp_q.pop_front());
    end
    got = i_valid && o_ready && !clear;
    if (clear) m_tap = 0;
    else if (got) model_beat();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [BW-1:0] pix, input logic [DW-1:0] w,
                           input logic [DW-1:0] b, input logic [AS-1:0] m, input bit r);
    bit got;
    got = 1'b0;
    i_pixel_bus = pix;
    i_weight    = w;
    i_bias      = b;
    i_lane_mask = m;
    i_relu      = r;
    i_valid     = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      tick(got);
      if (!got) i_ready = 1'b1;
    end
    check_val("accept_timeout", int'(got), 1);
  endtask

  function automatic logic [DW-1:0] rnd_small();
    int v;
    v = int'($urandom_range(0, 2047)) - 1024;
    return v[DW-1:0];
  endfunction

  function automatic logic [BW-1:0] rand_pix();
    logic [BW-1:0] v;
    for (int k = 0; k < AS; k++) v[(AS-k)*DW-1 -: DW] = rnd_small();
    return v;
  endfunction

  // Options on non-first beats are random junk that must be ignored.
  task automatic send_rand_taps(input logic [DW-1:0] b, input logic [AS-1:0] m, input bit r,
                                input int ntaps);
    for (int t = 0; t < ntaps; t++) begin
      if (t == 0) send_beat(rand_pix(), rnd_small(), b, m, r);
      else send_beat(rand_pix(), rnd_small(), DW'($urandom), AS'($urandom), 1'($urandom));
    end
  endtask

  task automatic send_const_window(input logic [BW-1:0] pix, input logic [DW-1:0] w,
                                   input logic [DW-1:0] b, input logic [AS-1:0] m, input bit r);
    for (int t = 0; t < KT; t++) begin
      if (t == 0) send_beat(pix, w, b, m, r);
      else send_beat(pix, w, 16'h7FFF, '0, ~r);
    end
  endtask

  task automatic wait_result();
    bit g;
    int n;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin
      tick(g);
      n++;
    end
    check_val("result_timeout", int'(o_valid), 1);
  endtask

  initial begin
    bit g;
    logic [BW-1:0] pix;
    logic [DW-1:0] w;

    rst_n = 1'b0;
    i_pixel_bus = '0; i_weight = '0; i_bias = '0; i_lane_mask = '0;
    i_relu = 1'b0; i_valid = 1'b0; clear = 1'b0; i_ready = 1'b1;
    #12;
    check_val("rst_o_valid", int'(o_valid), 0);
    check_bus("rst_o_bus", o_pixel_bus, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check_val("rst_o_ready", int'(o_ready), 1);

    // Ones window: 9 * 1.0 * 0.5 + 0.25 = 4.75 -> 0x04C0, 1-cycle pulse.
    send_const_window({AS{16'h0100}}, 16'h0080, 16'h0040, '1, 1'b0);
    check_val("lat_edge_e", int'(o_valid), 0);
    i_valid = 1'b0;
    tick(g);
    check_val("lat_edge_e1", int'(o_valid), 1);
    check_bus("ones_bus", o_pixel_bus, {AS{16'h04C0}});
    tick(g);
    check_val("valid_pulse", int'(o_valid), 0);

    // Saturation and ReLU.
    send_const_window({AS{16'h7FFF}}, 16'h7FFF, 16'h0000, '1, 1'b0);
    wait_result();
    check_bus("sat_pos", o_pixel_bus, {AS{16'h7FFF}});
    tick(g);
    send_const_window({AS{16'h7FFF}}, 16'h8001, 16'h0000, '1, 1'b0);
    wait_result();
    check_bus("sat_neg", o_pixel_bus, {AS{16'h8000}});
    tick(g);
    send_const_window({AS{16'h7FFF}}, 16'h8001, 16'h0000, '1, 1'b1);
    wait_result();
    check_bus("relu_neg", o_pixel_bus, '0);
    tick(g);

    // Mask and lane order: lane k pixel k+1, lane 0 in the MSBs.
    for (int k = 0; k < AS; k++) pix[(AS-k)*DW-1 -: DW] = DW'((k + 1) << FB);
    send_const_window(pix, 16'h0100, 16'h0000, 6'b101011, 1'b0);
    wait_result();
    check_bus("mask_order", o_pixel_bus,
              {16'h0900, 16'h1200, 16'h0000, 16'h2400, 16'h0000, 16'h3600});
    tick(g);

    // Backpressure: result of A held while B's second beat stalls.
    i_ready = 1'b0;
    send_rand_taps(16'h0020, '1, 1'b0, KT);
    send_rand_taps(rnd_small(), '1, 1'b0, 1);
    check_val("bp_valid_up", int'(o_valid), 1);
    check_val("bp_ready_drop", int'(o_ready), 0);
    pix = rand_pix();
    w = rnd_small();
    i_pixel_bus = pix; i_weight = w; i_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick(g);
      check_val("bp_stall", int'(g), 0);
    end
    check_bus("bp_hold_bus", o_pixel_bus, exp_q[0]);
    i_ready = 1'b1;
    send_beat(pix, w, '0, '0, 1'b1);
    send_rand_taps('0, '0, 1'b0, KT - 2);
    wait_result();
    tick(g);
    check_val("bp_drained", exp_q.size(), 0);

    // Clear with a pending result: the result must survive.
    send_rand_taps(rnd_small(), 6'b110011, 1'b1, KT);
    i_ready = 1'b0;
    wait_result();
    clear = 1'b1;
    tick(g);
    clear = 1'b0;
    check_val("clear_keeps_valid", int'(o_valid), 1);
    i_ready = 1'b1;
    tick(g);

    // Clear mid-window, with a discarded beat, then a fresh window.
    send_rand_taps(rnd_small(), '1, 1'b0, 5);
    clear = 1'b1;
    i_valid = 1'b1;
    tick(g);
    clear = 1'b0;
    send_rand_taps(rnd_small(), '1, 1'b0, KT);
    wait_result();
    tick(g);
    check_val("clear_drained", exp_q.size(), 0);

    // Reset mid-window: outputs clear at once, next window starts at tap 0.
    send_const_window({AS{16'h0300}}, 16'h0200, 16'h0010, '1, 1'b0);
    wait_result();
    tick(g);
    send_rand_taps(rnd_small(), '1, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    m_tap = 0;
    exp_q.delete();
    i_valid = 1'b0;
    check_val("rstm_o_valid", int'(o_valid), 0);
    check_bus("rstm_o_bus", o_pixel_bus, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    send_rand_taps(rnd_small(), '1, 1'b0, KT);
    wait_result();
    tick(g);

    // Randomized back-to-back windows with random downstream stalls.
    for (int win = 0; win < 8; win++) begin
      for (int t = 0; t < KT; t++) begin
        i_ready = 1'($urandom_range(0, 1));
        if (t == 0) send_beat(rand_pix(), rnd_small(), rnd_small(), AS'($urandom), 1'($urandom));
        else send_beat(rand_pix(), rnd_small(), DW'($urandom), AS'($urandom), 1'($urandom));
      end
    end

    // Drain.
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 10 && (exp_q.size() > 0 || o_valid); n++) tick(g);
    check_val("final_drained", exp_q.size(), 0);
    check_val("final_o_valid", int'(o_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
